// File: rtl/display_scan_controller_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package display_scan_controller_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4;
    localparam int DIGITS_W   = NUM_DIGITS * BCD_W;

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

    // True when digit idx is a suppressible leading zero: idx is not the
    // ones digit and nibble idx plus every more-significant nibble are 0.
    function automatic logic leading_zero(input logic [DIGITS_W-1:0] digits,
                                          input logic [1:0]          idx);
        logic lz;
        lz = (idx != 2'd0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx) && digits[k*BCD_W +: BCD_W] != '0) begin
                lz = 1'b0;
            end
        end
        return lz;
    endfunction

endpackage

// File: rtl/display_scan_controller_scan_dwell_timer.sv
// Dwell timer: counts 0..i_term and flags the terminal count.
// Latency: o_done is combinational from the count register.
// Backpressure: none; i_restart clears the count on the next edge.
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   i_restart  - clear the count (asserted on every FSM state change)
//   i_term     - terminal count (dwell length minus one) for the current state
//   o_done     - count has reached i_term this cycle
module scan_dwell_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_restart,
    input  logic [W-1:0] i_term,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_done = (r_cnt == i_term);

endmodule

// File: rtl/display_scan_controller.sv
// 4-digit seven-segment scan scheduler with blanking guard and frame-aligned digit commit.
// Latency: loaded digits appear at the next frame boundary; an/refreshcounter are registered.
// Backpressure: ready=0 while a value is pending; load is ignored until it commits.
//
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   load, digit_in  - offer of a new 4-digit BCD value, taken when ready=1
//   display_en      - 0 blanks all anodes; timing is unaffected
//   ready           - pending buffer empty
//   digits_q        - committed digits, [3:0]=ones
//   refreshcounter  - digit index currently selected (0=ones)
//   an              - active-low anode enables
//   frame_done      - one-cycle pulse in the first cycle of each new frame
//
// Build option: define LEADING_ZERO_BLANK_EN to keep leading-zero digits dark.
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DIGITS_W-1:0]   digit_in,
    input  logic                  display_en,
    output logic                  ready,
    output logic [DIGITS_W-1:0]   digits_q,
    output logic [1:0]            refreshcounter,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_done
);

    localparam int DWELL_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W     = $clog2(DWELL_MAX);
    localparam logic [CNT_W-1:0] SHOW_TERM  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_TERM = CNT_W'(BLANK_CYCLES - 1);

    scan_state_t             r_state;
    scan_state_t             w_state_nxt;
    logic [CNT_W-1:0]        w_term;
    logic                    w_done;
    logic                    w_wrap;
    logic                    w_lit;
    logic [NUM_DIGITS-1:0]   w_an_nxt;

    logic [1:0]              r_idx;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [DIGITS_W-1:0]     r_digits;
    logic [DIGITS_W-1:0]     r_pend;
    // r_ready doubles as the pending-buffer-empty flag.
    logic                    r_ready;
    logic                    r_frame_done;

    scan_dwell_timer #(
        .W (CNT_W)
    ) u_dwell (
        .clk       (clk),
        .rst       (reset),
        .i_restart (w_done),
        .i_term    (w_term),
        .o_done    (w_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_BLANK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Every dwell expiry is a state change, so the timer restarts on w_done.
    always_comb begin
        w_state_nxt = r_state;
        w_term      = BLANK_TERM;
        case (r_state)
            ST_BLANK: begin
                w_term = BLANK_TERM;
                if (w_done) begin
                    w_state_nxt = ST_SHOW;
                end
            end
            ST_SHOW: begin
                w_term = SHOW_TERM;
                if (w_done) begin
                    w_state_nxt = ST_BLANK;
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
            end
        endcase
    end

    // Last SHOW cycle of the leftmost digit: the frame boundary.
    assign w_wrap = (r_state == ST_SHOW) && w_done && (r_idx == 2'd3);

    // Anodes are computed from the next state so the registered value lines
    // up with the state it belongs to. The index only changes on SHOW->BLANK,
    // and digits only change on entry to BLANK, so current r_idx/r_digits are
    // the right ones whenever the next state is SHOW.
    always_comb begin
        w_an_nxt = ANODE_OFF;
        w_lit    = display_en;
`ifdef LEADING_ZERO_BLANK_EN
        if (leading_zero(r_digits, r_idx)) begin
            w_lit = 1'b0;
        end
`endif
        if (w_state_nxt == ST_SHOW && w_lit) begin
            w_an_nxt[r_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx        <= 2'd0;
            r_an         <= ANODE_OFF;
            r_digits     <= '0;
            r_pend       <= '0;
            r_ready      <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an_nxt;
            r_frame_done <= w_wrap;
            if (r_state == ST_SHOW && w_done) begin
                r_idx <= r_idx + 2'd1;
            end
            // A pending value blocks load, so commit and capture never collide;
            // a load on the boundary cycle with an empty buffer waits a frame.
            if (w_wrap && !r_ready) begin
                r_digits <= r_pend;
                r_ready  <= 1'b1;
            end else if (load && r_ready) begin
                r_pend  <= digit_in;
                r_ready <= 1'b0;
            end
        end
    end

    assign ready          = r_ready;
    assign digits_q       = r_digits;
    assign refreshcounter = r_idx;
    assign an             = r_an;
    assign frame_done     = r_frame_done;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller with REFRESH_DIV=4, BLANK_CYCLES=2 (24-cycle frame).
// Expected values are queued against the cycle number since reset release;
// a monitor compares each entry when that cycle is sampled.
module tb_display_scan_controller;

    localparam int K_AN  = 0;
    localparam int K_RC  = 1;
    localparam int K_DQ  = 2;
    localparam int K_RDY = 3;
    localparam int K_FD  = 4;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] exp;
    } chk_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digit_in = 16'h0000;
    logic        display_en = 1'b1;
    logic        ready;
    logic [15:0] digits_q;
    logic [1:0]  refreshcounter;
    logic [3:0]  an;
    logic        frame_done;

    int   tb_cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    chk_t chk_q[$];

    display_scan_controller #(
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load           (load),
        .digit_in       (digit_in),
        .display_en     (display_en),
        .ready          (ready),
        .digits_q       (digits_q),
        .refreshcounter (refreshcounter),
        .an             (an),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    // Cycle 0 is the state held in reset; cycle n follows the n-th edge after release.
    always @(posedge clk) begin
        if (reset) tb_cyc <= 0;
        else       tb_cyc <= tb_cyc + 1;
    end

    task automatic expect_at(input int c, input int k, input logic [15:0] v);
        chk_t e;
        e.cyc  = c;
        e.kind = k;
        e.exp  = v;
        chk_q.push_back(e);
    endtask

    function automatic string kind_name(input int k);
        case (k)
            K_AN:    return "an";
            K_RC:    return "refreshcounter";
            K_DQ:    return "digits_q";
            K_RDY:   return "ready";
            default: return "frame_done";
        endcase
    endfunction

    task automatic check_one(input chk_t e);
        logic [15:0] act;
        case (e.kind)
            K_AN:    act = {12'h000, an};
            K_RC:    act = {14'h0000, refreshcounter};
            K_DQ:    act = digits_q;
            K_RDY:   act = {15'h0000, ready};
            default: act = {15'h0000, frame_done};
        endcase
        n_checks++;
        if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", kind_name(e.kind), e.cyc, act, e.exp);
        end
    endtask

    // Monitor: sample away from the active edge and retire due entries.
    always @(negedge clk) begin
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].cyc == tb_cyc) begin
                check_one(chk_q[i]);
                chk_q.delete(i);
            end
        end
    end

    task automatic go_to(input int c);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (tb_cyc != c && guard < 400);
        if (tb_cyc != c) begin
            n_checks++;
            n_fail++;
            $display("FAIL go_to: cycle %0d not reached, at %0d", c, tb_cyc);
        end
    endtask

    task automatic expect_reset_state();
        expect_at(0, K_AN,  16'h000F);
        expect_at(0, K_RC,  16'h0000);
        expect_at(0, K_DQ,  16'h0000);
        expect_at(0, K_RDY, 16'h0001);
        expect_at(0, K_FD,  16'h0000);
    endtask

    initial begin
        // Reset values and the first-frame scan pattern.
        expect_reset_state();
        expect_at(1,  K_AN, 16'h000F);
        expect_at(2,  K_AN, 16'h000E);
        expect_at(5,  K_AN, 16'h000E);
        expect_at(6,  K_AN, 16'h000F);
        expect_at(7,  K_AN, 16'h000F);
        expect_at(8,  K_AN, LZB ? 16'h000F : 16'h000D);
        expect_at(11, K_AN, LZB ? 16'h000F : 16'h000D);
        expect_at(12, K_AN, 16'h000F);
        expect_at(20, K_AN, LZB ? 16'h000F : 16'h0007);
        expect_at(5,  K_RC, 16'h0000);
        expect_at(6,  K_RC, 16'h0001);
        expect_at(12, K_RC, 16'h0002);
        expect_at(18, K_RC, 16'h0003);
        expect_at(23, K_RC, 16'h0003);
        expect_at(24, K_RC, 16'h0000);
        expect_at(1,  K_FD, 16'h0000);
        expect_at(23, K_FD, 16'h0000);
        expect_at(24, K_FD, 16'h0001);
        expect_at(25, K_FD, 16'h0000);
        expect_at(24, K_AN, 16'h000F);
        expect_at(26, K_AN, 16'h000E);

        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        // Load mid-frame; commit only at the wrap.
        go_to(9);
        expect_at(10, K_RDY, 16'h0001);
        expect_at(11, K_RDY, 16'h0000);
        expect_at(23, K_RDY, 16'h0000);
        expect_at(11, K_DQ,  16'h0000);
        expect_at(23, K_DQ,  16'h0000);
        expect_at(24, K_DQ,  16'h1234);
        expect_at(24, K_RDY, 16'h0001);
        go_to(10);
        load = 1'b1; digit_in = 16'h1234;
        go_to(11);
        load = 1'b0;

        // Load while not ready is dropped.
        go_to(13);
        expect_at(15, K_RDY, 16'h0000);
        expect_at(16, K_RDY, 16'h0000);
        expect_at(25, K_DQ,  16'h1234);
        go_to(15);
        load = 1'b1; digit_in = 16'h9999;
        go_to(16);
        load = 1'b0;

        // Load on the commit cycle waits a full frame.
        go_to(45);
        expect_at(47, K_RDY, 16'h0001);
        expect_at(47, K_DQ,  16'h1234);
        expect_at(48, K_DQ,  16'h1234);
        expect_at(48, K_RDY, 16'h0000);
        expect_at(48, K_FD,  16'h0001);
        expect_at(71, K_DQ,  16'h1234);
        expect_at(72, K_DQ,  16'h5678);
        expect_at(72, K_RDY, 16'h0001);
        expect_at(72, K_FD,  16'h0001);
        go_to(47);
        load = 1'b1; digit_in = 16'h5678;
        go_to(48);
        load = 1'b0;

        // Display disabled for a whole frame: anodes dark, timing intact.
        go_to(70);
        expect_at(72, K_AN, 16'h000F);
        expect_at(74, K_AN, 16'h000F);
        expect_at(77, K_AN, 16'h000F);
        expect_at(80, K_AN, 16'h000F);
        expect_at(92, K_AN, 16'h000F);
        expect_at(95, K_AN, 16'h000F);
        expect_at(74, K_RC, 16'h0000);
        expect_at(80, K_RC, 16'h0001);
        expect_at(86, K_RC, 16'h0002);
        expect_at(92, K_RC, 16'h0003);
        expect_at(96, K_RC, 16'h0000);
        expect_at(95, K_FD, 16'h0000);
        expect_at(96, K_FD, 16'h0001);
        expect_at(96, K_DQ, 16'h5678);
        expect_at(98, K_AN, 16'h000E);
        go_to(71);
        display_en = 1'b0;
        go_to(95);
        display_en = 1'b1;

        // Leading-zero value 0042.
        go_to(99);
        expect_at(100, K_RDY, 16'h0001);
        expect_at(101, K_RDY, 16'h0000);
        expect_at(119, K_DQ,  16'h5678);
        expect_at(120, K_DQ,  16'h0042);
        expect_at(120, K_FD,  16'h0001);
        expect_at(122, K_AN,  16'h000E);
        expect_at(128, K_AN,  16'h000D);
        expect_at(134, K_AN,  LZB ? 16'h000F : 16'h000B);
        expect_at(140, K_AN,  LZB ? 16'h000F : 16'h0007);
        expect_at(134, K_RC,  16'h0002);
        expect_at(140, K_RC,  16'h0003);
        go_to(100);
        load = 1'b1; digit_in = 16'h0042;
        go_to(101);
        load = 1'b0;

        // Reset mid-SHOW with a value pending.
        go_to(148);
        expect_at(150, K_RDY, 16'h0001);
        expect_at(151, K_RDY, 16'h0000);
        expect_at(151, K_DQ,  16'h0042);
        expect_at(152, K_AN,  16'h000D);
        expect_at(153, K_AN,  16'h000D);
        go_to(150);
        load = 1'b1; digit_in = 16'h8765;
        go_to(151);
        load = 1'b0;
        go_to(153);
        #1 reset = 1'b1;
        expect_reset_state();
        expect_at(1,  K_RDY, 16'h0001);
        expect_at(2,  K_AN,  16'h000E);
        expect_at(8,  K_AN,  LZB ? 16'h000F : 16'h000D);
        expect_at(23, K_DQ,  16'h0000);
        expect_at(24, K_DQ,  16'h0000);
        expect_at(24, K_FD,  16'h0001);
        expect_at(24, K_RDY, 16'h0001);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        go_to(30);

        while (chk_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unchecked %s @cyc %0d", kind_name(chk_q[0].kind), chk_q[0].cyc);
            void'(chk_q.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
